nios_system_onchip_copy_master: RTL and testbench
=================================================

# nios_system_onchip_copy_master

Avalon-MM master that performs word-granular block copies inside the 1024 x 32 on-chip memory. It drives the memory's slave port (chipselect/read/write/byteenable, fixed read latency of 1, no readdatavalid). Software or a sprite engine issues a command (source, destination, length) over a valid/ready handshake. The block reports completion with a single-cycle pulse and offloads screen-buffer and tile moves from the Nios II.

## Interface
- ADDR_W, 10: word address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- LEN_W, 11: length field width; maximum 1024 words.

- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_src  in  ADDR_W  source start word address.
- cmd_dst  in  ADDR_W  destination start word address.
- cmd_len  in  LEN_W  word count; 0 is legal.
- cmd_fill  in  1  fill mode select; only honoured with MEMCOPY_FILL_EN.
- cmd_pattern  in  DATA_W  fill word; only honoured with MEMCOPY_FILL_EN.
- busy  out  1  high from command accept until the done cycle inclusive.
- done  out  1  one-cycle completion pulse.
- avm_address  out  ADDR_W  word address.
- avm_byteenable  out  DATA_W/8  all ones during a write, otherwise 0.
- avm_chipselect, avm_read, avm_write  out  1 each  bus strobes.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  valid exactly one cycle after an accepted read.
- avm_waitrequest  in  1  slave stall; tie to 0 for the on-chip memory.

## Operation
- FSM states: IDLE, READ, RDWAIT, WRITE, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch src, dst, len, fill and pattern, and clear the word index i.
  - Then go to DONE if len == 0, otherwise to READ (WRITE if fill is active).
- READ:
  - avm_chipselect = avm_read = 1 and avm_address = src+i.
  - Hold all signals while avm_waitrequest is high.
  - When the read is accepted, go to RDWAIT.
- RDWAIT: capture avm_readdata into the data register, then go to WRITE.
- WRITE:
  - avm_chipselect = avm_write = 1, avm_byteenable = all ones, avm_address = dst+i, avm_writedata = data register (or pattern in fill mode).
  - Hold while waitrequest is high.
  - When the write is accepted, increment i. Go to DONE if i+1 == len, else to READ (or stay in WRITE in fill mode).
- DONE: done = 1 and busy = 1 for one cycle, then go to IDLE.
- Address arithmetic is ADDR_W bits wide and wraps (src 1023 +1 -> 0). The index register is LEN_W bits wide.
- Overlapping regions are copied in ascending order only.
  - If dst is in (src, src+len), previously written words are re-read. This replication is the defined behaviour.
- Reset:
  - reset_n low at any edge puts the FSM in IDLE and clears i, done, busy and all avm_* outputs.
  - An in-flight command is abandoned with no done pulse.
  - cmd_ready is forced to 0 while reset_n is low.
- Reset values: every output is 0. cmd_ready becomes 1 on the first cycle after reset_n goes high.

## Timing
- Command accepted at edge E0. The first avm_read is visible in the cycle after E0.
- With waitrequest = 0, each copied word takes 3 cycles (READ, RDWAIT, WRITE).
  - done is asserted in cycle 3N+1 after E0; cmd_ready returns in cycle 3N+2.
- len = 0: done in cycle 1 after E0, with no bus traffic.
- Each waitrequest cycle extends the current READ or WRITE by exactly one cycle.
- cmd_ready is combinational from state; no command is accepted during busy.

## Configuration
- MEMCOPY_FILL_EN defined:
  - cmd_fill = 1 skips READ/RDWAIT and writes cmd_pattern to dst..dst+len-1.
  - Rate is 1 word/cycle with no stalls; done is in cycle N+1 after E0.
- MEMCOPY_FILL_EN undefined:
  - cmd_fill and cmd_pattern are ignored, and no fill datapath is synthesized.
  - Every command is a copy.

## Test plan
- Memory preloaded with word k = k. Copy src=0, dst=512, len=4 -> words 512..515 = 0..3; done in cycle 13 after accept; no other addresses written.
- len=0 -> done in cycle 1 after accept; avm_chipselect never asserted; memory unchanged.
- Wrap: src=1022, dst=100, len=4 -> dst words read from 1022, 1023, 0, 1.
- Random waitrequest (50%) during copy len=16 -> strobes and address stable while stalled; final contents match; done exactly once.
- Assert reset_n=0 for 1 cycle mid-copy (after 2 words) -> strobes drop at that edge; no done; a new command afterwards completes normally.
- With MEMCOPY_FILL_EN: fill dst=8, len=3, pattern 0xDEADBEEF -> words 8..10 = 0xDEADBEEF; no reads; done in cycle 4 after accept.

Source files
------------

// File: rtl/nios_system_onchip_copy_master_if.sv
// nios_system_onchip_copy_master_if
//
// Groups the two bundles that the copy master talks over.
// - Command handshake: cmd_valid/cmd_ready with src, dst, len, fill and pattern.
// - Status: busy and the done pulse.
// - Avalon-MM master port to the on-chip memory slave: chipselect, read, write,
//   byteenable, address, writedata, readdata and waitrequest.
//
// Modports:
// - master: the copy engine's view. It drives cmd_ready, status and the avm_* strobes.
// - slave:  the command source and memory side, used by the surrounding system or bench.
interface nios_system_onchip_copy_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_src;
  logic [ADDR_W-1:0]     cmd_dst;
  logic [LEN_W-1:0]      cmd_len;
  logic                  cmd_fill;
  logic [DATA_W-1:0]     cmd_pattern;
  logic                  busy;
  logic                  done;
  logic [ADDR_W-1:0]     avm_address;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_chipselect;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic [DATA_W-1:0]     avm_readdata;
  logic                  avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_pattern,
    input  avm_readdata, avm_waitrequest,
    output cmd_ready, busy, done,
    output avm_address, avm_byteenable, avm_chipselect, avm_read, avm_write,
    output avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_pattern,
    output avm_readdata, avm_waitrequest,
    input  cmd_ready, busy, done,
    input  avm_address, avm_byteenable, avm_chipselect, avm_read, avm_write,
    input  avm_writedata
  );
endinterface

// File: rtl/nios_system_onchip_copy_master.sv
// nios_system_onchip_copy_master
//
// Avalon-MM master that copies blocks of words inside the 1024 x 32 on-chip
// memory. The memory has a fixed read latency of 1 and no readdatavalid.
// Each copied word is moved with a READ, RDWAIT, WRITE sequence.
// Addresses wrap modulo 2^ADDR_W. Copies always run in ascending order, so
// overlapping forward copies replicate the leading source words.
//
// Ports:
// - clk:     rising-edge clock.
// - reset_n: synchronous, active-low reset.
// - bus:     master modport of nios_system_onchip_copy_master_if. It carries
//            the command handshake, busy/done and the Avalon-MM master signals.
//
// Optional feature:
// - MEMCOPY_FILL_EN: when defined, cmd_fill = 1 writes cmd_pattern to
//   dst..dst+len-1 at one word per cycle.
// - Without the macro, fill and pattern are ignored and no fill datapath exists.
module nios_system_onchip_copy_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic                              clk,
  input  logic                              reset_n,
  nios_system_onchip_copy_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, READ, RDWAIT, WRITE, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [LEN_W-1:0]    idx;
  logic [ADDR_W-1:0]   src_r;
  logic [ADDR_W-1:0]   dst_r;
  logic [LEN_W-1:0]    len_r;
  logic [DATA_W-1:0]   data_r;
  logic                accept;
  logic                last_word;
  logic                fill_cmd;
  logic                fill_active;

  logic                cmd_ready;
  logic                busy;
  logic                done;
  logic                cs;
  logic                rd;
  logic                wr;
  logic [DATA_W/8-1:0] be;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;

`ifdef MEMCOPY_FILL_EN
  logic                fill_r;
  logic [DATA_W-1:0]   pattern_r;

  assign fill_cmd    = bus.cmd_fill;
  assign fill_active = fill_r;

  always_ff @(posedge clk) begin
    if (accept) begin
      fill_r    <= bus.cmd_fill;
      pattern_r <= bus.cmd_pattern;
    end
  end
`else
  // Fill inputs are deliberately ignored in this build.
  logic unused_fill;
  assign unused_fill = ^{bus.cmd_fill, bus.cmd_pattern};
  assign fill_cmd    = 1'b0;
  assign fill_active = 1'b0;
`endif

  // cmd_ready already includes reset_n, so no command is taken during reset.
  assign accept    = bus.cmd_valid & cmd_ready;
  assign last_word = (idx + LEN_W'(1)) == len_r;

  // Control state: FSM and word index.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx <= '0;
      end else if (state == WRITE && !bus.avm_waitrequest) begin
        idx <= idx + LEN_W'(1);
      end
    end
  end

  // Command fields and the read-data holding register carry no reset.
  // They are always loaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_r <= bus.cmd_src;
      dst_r <= bus.cmd_dst;
      len_r <= bus.cmd_len;
    end
    // Read latency is exactly one cycle, so readdata is valid during RDWAIT.
    if (state == RDWAIT) begin
      data_r <= bus.avm_readdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cs        = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    be        = '0;
    addr      = '0;
    wdata     = '0;
    case (state)
      IDLE: begin
        cmd_ready = reset_n;
        if (bus.cmd_valid && reset_n) begin
          if (bus.cmd_len == '0) begin
            state_nxt = DONE;
          end else if (fill_cmd) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: begin
        busy = 1'b1;
        cs   = 1'b1;
        rd   = 1'b1;
        addr = src_r + idx[ADDR_W-1:0];
        if (!bus.avm_waitrequest) begin
          state_nxt = RDWAIT;
        end
      end
      RDWAIT: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        cs   = 1'b1;
        wr   = 1'b1;
        be   = '1;
        addr = dst_r + idx[ADDR_W-1:0];
`ifdef MEMCOPY_FILL_EN
        wdata = fill_r ? pattern_r : data_r;
`else
        wdata = data_r;
`endif
        if (!bus.avm_waitrequest) begin
          if (last_word) begin
            state_nxt = DONE;
          end else if (fill_active) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cmd_ready      = cmd_ready;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.avm_chipselect = cs;
  assign bus.avm_read       = rd;
  assign bus.avm_write      = wr;
  assign bus.avm_byteenable = be;
  assign bus.avm_address    = addr;
  assign bus.avm_writedata  = wdata;

endmodule

// File: tb/tb_nios_system_onchip_copy_master.sv
// Bench for nios_system_onchip_copy_master.
// A behavioural 1024 x 32 memory with optional random waitrequest sits behind the
// master. A reference copy of the memory produces the expected write stream,
// which is queued and compared as the DUT issues writes.
module tb_nios_system_onchip_copy_master;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  logic wr_rand = 1'b0;
  always #5 clk = ~clk;

  nios_system_onchip_copy_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

  nios_system_onchip_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DATA_W-1:0] mem     [0:1023];
  logic [DATA_W-1:0] exp_mem [0:1023];
  wr_t exq[$];
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int rd_cnt     = 0;
  int cs_cnt     = 0;
  logic        prev_stall = 1'b0;
  logic [44:0] prev_sig   = '0;

  // Memory slave: one-cycle read latency, writes land on the accepting edge.
  always @(posedge clk) begin
    if (bus.avm_chipselect && !bus.avm_waitrequest) begin
      if (bus.avm_read)  bus.avm_readdata <= mem[bus.avm_address];
      if (bus.avm_write) mem[bus.avm_address] <= bus.avm_writedata;
    end
  end

  always @(posedge clk) begin
    #1 bus.avm_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: scoreboard pops, stall stability, event counters.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.done) done_cnt++;
      if (bus.avm_chipselect) cs_cnt++;
      if (bus.avm_chipselect && bus.avm_read && !bus.avm_waitrequest) rd_cnt++;
      if (prev_stall) begin
        check("stall_hold", {bus.avm_chipselect, bus.avm_read, bus.avm_write,
                             bus.avm_address, bus.avm_writedata}, prev_sig);
      end
      if (bus.avm_chipselect && bus.avm_write && !bus.avm_waitrequest) begin
        check("write_expected", exq.size() != 0, 1);
        if (exq.size() != 0) begin
          wr_t e;
          e = exq.pop_front();
          check("wr_addr", bus.avm_address, e.a);
          check("wr_data", bus.avm_writedata, e.d);
          check("wr_be", bus.avm_byteenable, 4'hF);
        end
      end
      prev_stall = bus.avm_chipselect && bus.avm_waitrequest;
      prev_sig   = {bus.avm_chipselect, bus.avm_read, bus.avm_write,
                    bus.avm_address, bus.avm_writedata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic model_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-1:0] as, ad;
      wr_t e;
      as = ADDR_W'(s + i);
      ad = ADDR_W'(d + i);
      exp_mem[ad] = exp_mem[as];
      e.a = ad;
      e.d = exp_mem[ad];
      exq.push_back(e);
    end
  endtask

  task automatic model_fill(input int d, input int n, input logic [DATA_W-1:0] p);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.a = ADDR_W'(d + i);
      e.d = p;
      exp_mem[e.a] = p;
      exq.push_back(e);
    end
  endtask

  task automatic drive_cmd(input int s, input int d, input int n, input logic f,
                           input logic [DATA_W-1:0] p);
    int k = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_src     = ADDR_W'(s);
    bus.cmd_dst     = ADDR_W'(d);
    bus.cmd_len     = LEN_W'(n);
    bus.cmd_fill    = f;
    bus.cmd_pattern = p;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Returns the cycle (1 = first cycle after accept) in which done is seen, or -1.
  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_ready_back"}, {bus.cmd_ready, bus.busy, bus.done}, 3'b100);
  endtask

  task automatic verify_mem(input string tag);
    int diffs = 0;
    for (int k = 0; k < 1024; k++) if (mem[k] !== exp_mem[k]) diffs++;
    check({tag, "_mem_diffs"}, diffs, 0);
    check({tag, "_sb_drained"}, exq.size(), 0);
  endtask

  initial begin
    int c, r0, d0, c0;
    reset_n         = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_src     = '0;
    bus.cmd_dst     = '0;
    bus.cmd_len     = '0;
    bus.cmd_fill    = 1'b0;
    bus.cmd_pattern = '0;
    for (int k = 0; k < 1024; k++) begin
      mem[k]     <= DATA_W'(k);
      exp_mem[k]  = DATA_W'(k);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.cmd_ready, bus.busy, bus.done, bus.avm_chipselect,
                            bus.avm_read, bus.avm_write, bus.avm_byteenable,
                            bus.avm_address, bus.avm_writedata}, 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_reset", bus.cmd_ready, 1);

    // Basic copy of four words.
    r0 = rd_cnt;
    model_copy(0, 512, 4);
    drive_cmd(0, 512, 4, 1'b0, '0);
    wait_done(100, c);
    check("copy4_done_cycle", c, 13);
    after_done("copy4");
    verify_mem("copy4");
    check("copy4_w512", mem[512], 0);
    check("copy4_w515", mem[515], 3);
    check("copy4_reads", rd_cnt - r0, 4);

    // Zero length: immediate done, no bus activity.
    c0 = cs_cnt;
    drive_cmd(5, 700, 0, 1'b0, '0);
    wait_done(20, c);
    check("len0_done_cycle", c, 1);
    after_done("len0");
    check("len0_no_cs", cs_cnt - c0, 0);
    verify_mem("len0");

    // Source address wraps past 1023.
    model_copy(1022, 100, 4);
    drive_cmd(1022, 100, 4, 1'b0, '0);
    wait_done(100, c);
    check("wrap_done_cycle", c, 13);
    after_done("wrap");
    verify_mem("wrap");
    check("wrap_w100", mem[100], 1022);
    check("wrap_w101", mem[101], 1023);
    check("wrap_w102", mem[102], 0);
    check("wrap_w103", mem[103], 1);

    // Random waitrequest during a 16-word copy.
    d0 = done_cnt;
    wr_rand = 1'b1;
    model_copy(200, 300, 16);
    drive_cmd(200, 300, 16, 1'b0, '0);
    wait_done(1000, c);
    check("stall_done_seen", c > 0, 1);
    wr_rand = 1'b0;
    repeat (4) @(negedge clk);
    check("stall_done_once", done_cnt - d0, 1);
    verify_mem("stall");

    // Overlapping forward copy replicates the first source word.
    model_copy(400, 401, 4);
    drive_cmd(400, 401, 4, 1'b0, '0);
    wait_done(100, c);
    check("overlap_done_cycle", c, 13);
    after_done("overlap");
    verify_mem("overlap");
    check("overlap_w404", mem[404], 400);

    // Reset asserted for one cycle after two words of an 8-word copy.
    model_copy(0, 600, 2);
    drive_cmd(0, 600, 8, 1'b0, '0);
    for (int k = 0; k < 100 && exq.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("rst_two_words", exq.size(), 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_reading_third", {bus.avm_chipselect, bus.avm_read}, 2'b11);
    d0 = done_cnt;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_outputs_drop", {bus.avm_chipselect, bus.avm_read, bus.avm_write,
                               bus.busy, bus.done, bus.cmd_ready}, 6'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle_ready", {bus.cmd_ready, bus.busy}, 2'b10);
    verify_mem("rst");

    // Normal copy after reset.
    model_copy(10, 20, 3);
    drive_cmd(10, 20, 3, 1'b0, '0);
    wait_done(100, c);
    check("post_rst_done_cycle", c, 10);
    after_done("post_rst");
    verify_mem("post_rst");

`ifdef MEMCOPY_FILL_EN
    r0 = rd_cnt;
    model_fill(8, 3, 32'hDEADBEEF);
    drive_cmd(0, 8, 3, 1'b1, 32'hDEADBEEF);
    wait_done(100, c);
    check("fill_done_cycle", c, 4);
    after_done("fill");
    check("fill_no_reads", rd_cnt - r0, 0);
    verify_mem("fill");
    check("fill_w9", mem[9], 32'hDEADBEEF);
`else
    // Fill request is ignored: behaves as a copy.
    model_copy(30, 40, 2);
    drive_cmd(30, 40, 2, 1'b1, 32'hDEADBEEF);
    wait_done(100, c);
    check("nofill_done_cycle", c, 7);
    after_done("nofill");
    verify_mem("nofill");
    check("nofill_w40", mem[40], 30);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
